// File: rtl/trena_multi_uc.sv
// Multi-channel tape-measure control unit: one measurement and one N_DIGITOS-char frame per channel, then a timed interval.
// Optional measurement watchdog enabled by defining TRENA_WATCHDOG_MEDIDA_EN.
//
// state      | meaning
// INICIAL    | idle, datapath held clear, waits for mensurar
// PREPARA    | clear datapath and char index before a channel
// MEDE       | selected channel measuring, waits for fim_medida
// TRANSMITE  | one-cycle TX start for current character
// ESPERA_TX  | waits for fim_digito
// PROX_CHAR  | advance character index or finish frame
// PROX_CANAL | advance channel or start interval
// INTERVALO  | programmable wait, stop request honoured here
// FINAL      | one-cycle pronto
// ERRO       | watchdog expired, channel frame skipped
module trena_multi_uc #(
    parameter int N_CANAIS          = 4,
    parameter int N_DIGITOS         = 7,
    parameter int INTERVALO_CICLOS  = 50_000_000,
    parameter int MEDIDA_MAX_CICLOS = 2_000_000,
    localparam int CW = (N_CANAIS  > 1) ? $clog2(N_CANAIS)  : 1,
    localparam int DW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mensurar,
    input  logic          parar,
    input  logic          fim_medida,
    input  logic          fim_digito,
    output logic          zera,
    output logic          comeca_medida,
    output logic          partida,
    output logic [CW-1:0] canal,
    output logic [DW-1:0] indice_char,
    output logic          pronto,
    output logic          erro_medida,
    output logic [3:0]    db_estado
);

    localparam int IW = (INTERVALO_CICLOS > 1) ? $clog2(INTERVALO_CICLOS) : 1;

    typedef enum logic [3:0] {
        S_INICIAL    = 4'd0,
        S_PREPARA    = 4'd1,
        S_MEDE       = 4'd2,
        S_TRANSMITE  = 4'd3,
        S_ESPERA_TX  = 4'd4,
        S_PROX_CHAR  = 4'd5,
        S_PROX_CANAL = 4'd6,
        S_INTERVALO  = 4'd7,
        S_FINAL      = 4'd8,
        S_ERRO       = 4'd9
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_canal;
    logic [DW-1:0] r_indice;
    logic [IW-1:0] r_intervalo;
    logic          r_parada_pend;

`ifdef TRENA_WATCHDOG_MEDIDA_EN
    localparam int WW = $clog2(MEDIDA_MAX_CICLOS);
    logic [WW-1:0] r_watchdog;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_INICIAL;
            r_canal       <= '0;
            r_indice      <= '0;
            r_intervalo   <= '0;
            r_parada_pend <= 1'b0;
`ifdef TRENA_WATCHDOG_MEDIDA_EN
            r_watchdog    <= '0;
`endif
        end else begin
            // Stop is only latched here; it is acted on in INTERVALO so a sweep always completes.
            if (parar && r_state != S_INICIAL)
                r_parada_pend <= 1'b1;
            case (r_state)
                S_INICIAL: begin
                    r_canal       <= '0;
                    r_indice      <= '0;
                    r_parada_pend <= 1'b0;
                    if (mensurar)
                        r_state <= S_PREPARA;
                end
                S_PREPARA: begin
                    r_indice <= '0;
`ifdef TRENA_WATCHDOG_MEDIDA_EN
                    r_watchdog <= '0;
`endif
                    r_state  <= S_MEDE;
                end
                S_MEDE: begin
                    if (fim_medida)
                        r_state <= S_TRANSMITE;
`ifdef TRENA_WATCHDOG_MEDIDA_EN
                    else if (r_watchdog == WW'(MEDIDA_MAX_CICLOS - 1))
                        r_state <= S_ERRO;
                    else
                        r_watchdog <= r_watchdog + 1'b1;
`endif
                end
                S_TRANSMITE: r_state <= S_ESPERA_TX;
                S_ESPERA_TX: begin
                    if (fim_digito)
                        r_state <= S_PROX_CHAR;
                end
                S_PROX_CHAR: begin
                    if (r_indice == DW'(N_DIGITOS - 1)) begin
                        r_state <= S_PROX_CANAL;
                    end else begin
                        r_indice <= r_indice + 1'b1;
                        r_state  <= S_TRANSMITE;
                    end
                end
                S_PROX_CANAL: begin
                    if (r_canal == CW'(N_CANAIS - 1)) begin
                        r_canal     <= '0;
                        r_intervalo <= '0;
                        r_state     <= S_INTERVALO;
                    end else begin
                        r_canal <= r_canal + 1'b1;
                        r_state <= S_PREPARA;
                    end
                end
                S_INTERVALO: begin
                    if (r_parada_pend || parar)
                        r_state <= S_FINAL;
                    else if (r_intervalo == IW'(INTERVALO_CICLOS - 1))
                        r_state <= S_PREPARA;
                    else
                        r_intervalo <= r_intervalo + 1'b1;
                end
                S_FINAL: r_state <= S_INICIAL;
                S_ERRO:  r_state <= S_PROX_CANAL;
                default: r_state <= S_INICIAL;
            endcase
        end
    end

    assign zera          = (r_state == S_INICIAL) || (r_state == S_PREPARA);
    assign comeca_medida = (r_state == S_MEDE);
    assign partida       = (r_state == S_TRANSMITE);
    assign pronto        = (r_state == S_FINAL);
    assign canal         = r_canal;
    assign indice_char   = r_indice;
    assign db_estado     = r_state;
`ifdef TRENA_WATCHDOG_MEDIDA_EN
    assign erro_medida   = (r_state == S_ERRO);
`else
    assign erro_medida   = 1'b0;
`endif

endmodule

// File: tb/tb_trena_multi_uc.sv
// Directed bench for trena_multi_uc with N_CANAIS=2, N_DIGITOS=3, INTERVALO_CICLOS=5, MEDIDA_MAX_CICLOS=8.
module tb_trena_multi_uc;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mensurar = 1'b0;
    logic       parar = 1'b0;
    logic       fim_medida = 1'b0;
    logic       fim_digito = 1'b0;
    logic       zera, comeca_medida, partida, pronto, erro_medida;
    logic [0:0] canal;
    logic [1:0] indice_char;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_pass   = 0;
    int n_partida = 0;
    int n_pronto  = 0;
    int n_erro    = 0;

    trena_multi_uc #(
        .N_CANAIS(2), .N_DIGITOS(3), .INTERVALO_CICLOS(5), .MEDIDA_MAX_CICLOS(8)
    ) dut (
        .clock(clock), .reset(reset), .mensurar(mensurar), .parar(parar),
        .fim_medida(fim_medida), .fim_digito(fim_digito), .zera(zera),
        .comeca_medida(comeca_medida), .partida(partida), .canal(canal),
        .indice_char(indice_char), .pronto(pronto), .erro_medida(erro_medida),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (partida)     n_partida++;
            if (pronto)      n_pronto++;
            if (erro_medida) n_erro++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // From PREPARA of channel c: measurement completes on the 2nd MEDE cycle.
    task automatic mede_to_tx(input int c);
        chk("prepara_state", db_estado, 1);
        chk("prepara_canal", canal, c);
        chk("prepara_zera", zera, 1);
        tick();
        chk("mede_state", db_estado, 2);
        chk("mede_comeca", comeca_medida, 1);
        chk("mede_zera", zera, 0);
        tick();
        chk("mede_hold", db_estado, 2);
        fim_medida = 1'b1;
        tick();
        fim_medida = 1'b0;
        chk("tx_state", db_estado, 3);
        chk("tx_partida", partida, 1);
    endtask

    // From TRANSMITE of char d; stops in ESPERA_TX when to_espera is set.
    task automatic send_char(input int c, input int d, input bit last, input bit to_espera);
        chk("char_idx", indice_char, d);
        chk("char_canal", canal, c);
        tick();
        parar = 1'b0;
        chk("espera_state", db_estado, 4);
        chk("espera_partida", partida, 0);
        if (!to_espera) begin
            tick();
            tick();
            chk("espera_hold", db_estado, 4);
            fim_digito = 1'b1;
            tick();
            fim_digito = 1'b0;
            chk("proxchar_state", db_estado, 5);
            tick();
            chk("after_char", db_estado, last ? 6 : 3);
        end
    endtask

    task automatic sweep(input bit with_parar);
        for (int c = 0; c < 2; c++) begin
            mede_to_tx(c);
            if (with_parar && c == 1) parar = 1'b1;
            for (int d = 0; d < 3; d++)
                send_char(c, d, d == 2, 1'b0);
            tick();
            if (c == 0) begin
                chk("next_canal_state", db_estado, 1);
                chk("next_canal", canal, 1);
            end else begin
                chk("intervalo_state", db_estado, 7);
                chk("intervalo_canal", canal, 0);
            end
        end
    endtask

    initial begin
        #1;
        chk("rst_state", db_estado, 0);
        chk("rst_zera", zera, 1);
        chk("rst_partida", partida, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_comeca", comeca_medida, 0);
        chk("rst_erro", erro_medida, 0);
        chk("rst_canal", canal, 0);
        chk("rst_idx", indice_char, 0);
        tick();
        reset = 1'b0;
        tick();
        fim_digito = 1'b1;
        fim_medida = 1'b1;
        tick();
        fim_digito = 1'b0;
        fim_medida = 1'b0;
        chk("idle_ignores_inputs", db_estado, 0);

        // Sweep with stop raised during channel 1.
        mensurar = 1'b1;
        tick();
        mensurar = 1'b0;
        sweep(1'b1);
        tick();
        chk("stop_final", db_estado, 8);
        chk("stop_pronto", pronto, 1);
        tick();
        chk("stop_inicial", db_estado, 0);
        chk("stop_pronto_off", pronto, 0);
        chk("partidas_sweep1", n_partida, 6);
        chk("pronto_count1", n_pronto, 1);

        // Two sweeps separated by a full interval, then stop at expiry.
        mensurar = 1'b1;
        tick();
        mensurar = 1'b0;
        sweep(1'b0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("intervalo_hold", db_estado, 7);
        end
        tick();
        chk("intervalo_expire", db_estado, 1);
        sweep(1'b0);
        for (int i = 1; i < 5; i++) tick();
        chk("last_interval_cycle", db_estado, 7);
        parar = 1'b1;
        tick();
        parar = 1'b0;
        chk("stop_beats_expiry", db_estado, 8);
        tick();
        chk("back_inicial", db_estado, 0);
        chk("partidas_total", n_partida, 18);
        chk("pronto_count2", n_pronto, 2);

        // Channel 0 never completes its measurement.
        mensurar = 1'b1;
        tick();
        mensurar = 1'b0;
        tick();
        chk("wd_mede_entry", db_estado, 2);
`ifdef TRENA_WATCHDOG_MEDIDA_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("wd_mede_hold", db_estado, 2);
            chk("wd_no_erro", erro_medida, 0);
        end
        tick();
        chk("wd_erro_state", db_estado, 9);
        chk("wd_erro_pulse", erro_medida, 1);
        tick();
        chk("wd_prox_canal", db_estado, 6);
        chk("wd_erro_off", erro_medida, 0);
        tick();
        chk("wd_erro_count", n_erro, 1);
        chk("wd_no_partida", n_partida, 18);
`else
        fim_digito = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        fim_digito = 1'b0;
        chk("nowd_mede_hold", db_estado, 2);
        chk("nowd_no_erro", n_erro, 0);
        fim_medida = 1'b1;
        tick();
        fim_medida = 1'b0;
        for (int d = 0; d < 3; d++)
            send_char(0, d, d == 2, 1'b0);
        tick();
`endif
        // Channel 1 runs up to waiting on the third character, then reset hits.
        mede_to_tx(1);
        send_char(1, 0, 1'b0, 1'b0);
        send_char(1, 1, 1'b0, 1'b0);
        send_char(1, 2, 1'b1, 1'b1);
        chk("pre_rst_idx", indice_char, 2);
        chk("pre_rst_canal", canal, 1);
        reset = 1'b1;
        #1;
        chk("midrst_state", db_estado, 0);
        chk("midrst_canal", canal, 0);
        chk("midrst_idx", indice_char, 0);
        chk("midrst_zera", zera, 1);
        tick();
        reset = 1'b0;
        fim_digito = 1'b1;
        tick();
        fim_digito = 1'b0;
        tick();
        chk("post_rst_state", db_estado, 0);
        chk("post_rst_no_pronto", n_pronto, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
